// File: rtl/input_mem_pkg.sv
// Shared constants, state encoding and stream beat type for the APB-loaded byte source.
package input_mem_pkg;

  localparam int unsigned DEF_WORDS_LOG2 = 10;
  localparam int unsigned APB_AW         = 32;
  localparam int unsigned APB_DW         = 32;
  localparam int unsigned BYTE_W         = 8;
  localparam int unsigned CNT_W          = 13;
  localparam int unsigned REG_SEL_BIT    = 12;
  localparam int unsigned MAX_LEN        = 4096;

  localparam logic [3:0] OFF_CTRL   = 4'h0;
  localparam logic [3:0] OFF_LEN    = 4'h4;
  localparam logic [3:0] OFF_STATUS = 4'h8;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_LOAD   = 2'd1,
    ST_STREAM = 2'd2
  } state_t;

  typedef struct packed {
    logic [BYTE_W-1:0] data;
    logic              last;
  } axis_beat_t;

  // Clamp a software-written length to the buffer's byte capacity.
  function automatic logic [CNT_W-1:0] sat_len(input logic [APB_DW-1:0] v);
    return (v > APB_DW'(MAX_LEN)) ? CNT_W'(MAX_LEN) : v[CNT_W-1:0];
  endfunction

endpackage

// File: rtl/input_mem_ram.sv
// Simple dual-port word RAM: port A is APB read/write, port B is the stream read.
module input_mem_ram
  import input_mem_pkg::*;
#(
  parameter int unsigned ADDR_W = DEF_WORDS_LOG2,
  parameter int unsigned DATA_W = APB_DW
) (
  input  logic              clk,
  input  logic              a_en,
  input  logic              a_we,
  input  logic [ADDR_W-1:0] a_addr,
  input  logic [DATA_W-1:0] a_wdata,
  output logic [DATA_W-1:0] a_rdata,
  input  logic              b_en,
  input  logic [ADDR_W-1:0] b_addr,
  output logic [DATA_W-1:0] b_rdata
);

  localparam int unsigned DEPTH = 1 << ADDR_W;

  logic [DATA_W-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (a_en) begin
      if (a_we) begin
        mem[a_addr] <= a_wdata;
      end else begin
        a_rdata <= mem[a_addr];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (b_en) begin
      b_rdata <= mem[b_addr];
    end
  end

endmodule

// File: rtl/input_mem.sv
// APB-loaded byte source: software fills a word buffer, sets LEN and START, and the
// block streams LEN bytes (LSB first) on an AXI-Stream master with tlast on the final byte.
module input_mem
  import input_mem_pkg::*;
#(
  parameter int unsigned WORDS_LOG2 = DEF_WORDS_LOG2
) (
  input  logic              S_APB_aclk,
  input  logic              S_APB_aresetn,
  input  logic [APB_AW-1:0] S_APB_paddr,
  input  logic              S_APB_psel,
  input  logic              S_APB_penable,
  input  logic              S_APB_pwrite,
  input  logic [APB_DW-1:0] S_APB_pwdata,
  output logic [APB_DW-1:0] S_APB_prdata,
  output logic              S_APB_pready,
  output logic              S_APB_pslverr,
  output logic [BYTE_W-1:0] M_AXIS_tdata,
  output logic              M_AXIS_tvalid,
  input  logic              M_AXIS_tready,
  output logic              M_AXIS_tkeep,
  output logic              M_AXIS_tlast
);

  logic                  access_c;
  logic                  is_reg_c;
  logic [1:0]            reg_off_c;
  logic                  reg_wr_c;
  logic                  reg_rd_c;
  logic                  buf_wr_c;
  logic                  buf_rd_c;
  logic                  buf_err_c;
  logic                  start_c;
  logic                  len_wr_c;
  logic [APB_DW-1:0]     reg_rdata_c;
  logic                  hs_c;
  logic                  wrap_c;
  logic [CNT_W-1:0]      cnt_inc_c;
  logic [CNT_W-1:0]      len_m1_c;
  logic                  ram_b_en_c;
  logic [WORDS_LOG2-1:0] ram_b_addr_c;
  logic [APB_DW-1:0]     ram_a_rdata;
  logic [APB_DW-1:0]     ram_b_rdata;
  logic                  unused_paddr;

  state_t                state_q;
  logic                  busy_q;
  logic                  done_q;
  logic [CNT_W-1:0]      cnt_q;
  logic [CNT_W-1:0]      len_q;
  logic [APB_DW-1:0]     sr_q;
  axis_beat_t            beat_q;
  logic                  tvalid_q;
  logic [APB_DW-1:0]     prdata_q;
  logic                  rd_buf_q;

  // An access is the psel && penable cycle before pready; the pready cycle is not a new access.
  assign access_c  = S_APB_psel & S_APB_penable & ~S_APB_pready;
  assign is_reg_c  = S_APB_paddr[REG_SEL_BIT];
  assign reg_off_c = S_APB_paddr[3:2];
  assign reg_wr_c  = access_c &  S_APB_pwrite &  is_reg_c;
  assign reg_rd_c  = access_c & ~S_APB_pwrite &  is_reg_c;
  assign buf_wr_c  = access_c &  S_APB_pwrite & ~is_reg_c & ~busy_q;
  assign buf_rd_c  = access_c & ~S_APB_pwrite & ~is_reg_c;
  assign buf_err_c = access_c &  S_APB_pwrite & ~is_reg_c &  busy_q;
  assign start_c   = reg_wr_c & (reg_off_c == OFF_CTRL[3:2]) & S_APB_pwdata[0] &
                     (state_q == ST_IDLE) & (len_q != '0);
  assign len_wr_c  = reg_wr_c & (reg_off_c == OFF_LEN[3:2]) & ~busy_q;
  assign unused_paddr = ^S_APB_paddr;

  always_comb begin
    reg_rdata_c = '0;
    case (reg_off_c)
      OFF_LEN[3:2]:    reg_rdata_c = APB_DW'(len_q);
      OFF_STATUS[3:2]: reg_rdata_c = APB_DW'({done_q, busy_q});
      default:         reg_rdata_c = '0;
    endcase
  end

  // APB response and register file.
  always_ff @(posedge S_APB_aclk or negedge S_APB_aresetn) begin
    if (!S_APB_aresetn) begin
      S_APB_pready  <= 1'b0;
      S_APB_pslverr <= 1'b0;
      prdata_q      <= '0;
      rd_buf_q      <= 1'b0;
      len_q         <= '0;
    end else begin
      S_APB_pready  <= access_c;
      S_APB_pslverr <= buf_err_c;
      rd_buf_q      <= buf_rd_c;
      prdata_q      <= reg_rd_c ? reg_rdata_c : '0;
      if (len_wr_c) begin
        len_q <= sat_len(S_APB_pwdata);
      end
    end
  end

  // Buffer reads come straight from the RAM's registered port A output.
  assign S_APB_prdata = rd_buf_q ? ram_a_rdata : prdata_q;

  assign hs_c      = tvalid_q & M_AXIS_tready;
  assign cnt_inc_c = cnt_q + CNT_W'(1);
  assign len_m1_c  = len_q - CNT_W'(1);
  assign wrap_c    = (state_q == ST_STREAM) & hs_c & ~beat_q.last & (cnt_q[1:0] == 2'd3);

  // The word is fetched on the cycle that enters LOAD so it is ready to register during LOAD.
  assign ram_b_en_c   = start_c | wrap_c;
  assign ram_b_addr_c = start_c ? '0 : cnt_inc_c[WORDS_LOG2+1:2];

  input_mem_ram #(
    .ADDR_W (WORDS_LOG2),
    .DATA_W (APB_DW)
  ) u_ram (
    .clk     (S_APB_aclk),
    .a_en    (buf_wr_c | buf_rd_c),
    .a_we    (buf_wr_c),
    .a_addr  (S_APB_paddr[WORDS_LOG2+1:2]),
    .a_wdata (S_APB_pwdata),
    .a_rdata (ram_a_rdata),
    .b_en    (ram_b_en_c),
    .b_addr  (ram_b_addr_c),
    .b_rdata (ram_b_rdata)
  );

  // Stream FSM: LOAD registers a word, STREAM emits its bytes, one bubble per word.
  always_ff @(posedge S_APB_aclk or negedge S_APB_aresetn) begin
    if (!S_APB_aresetn) begin
      state_q  <= ST_IDLE;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      cnt_q    <= '0;
      sr_q     <= '0;
      beat_q   <= '0;
      tvalid_q <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (start_c) begin
            busy_q  <= 1'b1;
            done_q  <= 1'b0;
            cnt_q   <= '0;
            state_q <= ST_LOAD;
          end
        end
        ST_LOAD: begin
          beat_q.data <= ram_b_rdata[BYTE_W-1:0];
          beat_q.last <= (cnt_q == len_m1_c);
          sr_q        <= ram_b_rdata >> BYTE_W;
          tvalid_q    <= 1'b1;
          state_q     <= ST_STREAM;
        end
        ST_STREAM: begin
          if (hs_c) begin
            cnt_q <= cnt_inc_c;
            if (beat_q.last) begin
              tvalid_q    <= 1'b0;
              beat_q.last <= 1'b0;
              busy_q      <= 1'b0;
              done_q      <= 1'b1;
              state_q     <= ST_IDLE;
            end else if (cnt_q[1:0] == 2'd3) begin
              tvalid_q <= 1'b0;
              state_q  <= ST_LOAD;
            end else begin
              beat_q.data <= sr_q[BYTE_W-1:0];
              beat_q.last <= (cnt_inc_c == len_m1_c);
              sr_q        <= sr_q >> BYTE_W;
            end
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign M_AXIS_tdata  = beat_q.data;
  assign M_AXIS_tlast  = beat_q.last;
  assign M_AXIS_tvalid = tvalid_q;
  assign M_AXIS_tkeep  = 1'b1;

endmodule

// File: tb/tb_input_mem.sv
// Bench for input_mem: byte-queue model of the transfer checked on every stream cycle,
// plus directed APB accesses with hand-computed expectations.
module tb_input_mem;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] paddr;
  logic        psel;
  logic        penable;
  logic        pwrite;
  logic [31:0] pwdata;
  logic [31:0] prdata;
  logic        pready;
  logic        pslverr;
  logic [7:0]  tdata;
  logic        tvalid;
  logic        tready;
  logic        tkeep;
  logic        tlast;

  always #5 clk = ~clk;

  input_mem dut (
    .S_APB_aclk    (clk),
    .S_APB_aresetn (rst_n),
    .S_APB_paddr   (paddr),
    .S_APB_psel    (psel),
    .S_APB_penable (penable),
    .S_APB_pwrite  (pwrite),
    .S_APB_pwdata  (pwdata),
    .S_APB_prdata  (prdata),
    .S_APB_pready  (pready),
    .S_APB_pslverr (pslverr),
    .M_AXIS_tdata  (tdata),
    .M_AXIS_tvalid (tvalid),
    .M_AXIS_tready (tready),
    .M_AXIS_tkeep  (tkeep),
    .M_AXIS_tlast  (tlast)
  );

  typedef struct {
    logic [7:0] d;
    logic       l;
  } exp_t;

  exp_t        exp_q[$];
  logic [7:0]  acc_q[$];
  logic [31:0] mdl_mem [1024];
  int unsigned mdl_len;
  logic        mdl_done;
  int          checks = 0;
  int          errors = 0;
  int          hs_count = 0;
  int          last_count = 0;
  int          cyc = 0;
  int          first_cyc = 0;
  int          last_cyc = 0;
  bit          in_xfer = 1'b0;

  always @(posedge clk) cyc++;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: actual=%0h required=%0h (t=%0t)", name, act, req, $time);
    end
  endtask

  // Stream compare: every valid cycle must present the head of the expected byte queue.
  always @(negedge clk) begin
    if (rst_n && tvalid) begin
      if (!in_xfer) begin
        in_xfer   = 1'b1;
        first_cyc = cyc;
      end
      if (exp_q.size() == 0) begin
        chk("tvalid_unexpected", 32'(tvalid), 32'd0);
      end else begin
        chk("tdata", 32'(tdata), 32'(exp_q[0].d));
        chk("tlast", 32'(tlast), 32'(exp_q[0].l));
        chk("tkeep", 32'(tkeep), 32'd1);
        if (tready) begin
          hs_count++;
          acc_q.push_back(tdata);
          if (exp_q[0].l) begin
            last_count++;
            mdl_done = 1'b1;
            in_xfer  = 1'b0;
            last_cyc = cyc;
          end
          void'(exp_q.pop_front());
        end
      end
    end
  end

  function automatic logic [31:0] mdl_read(input logic [31:0] a);
    logic busy;
    busy = (exp_q.size() != 0);
    if (a[12]) begin
      case (a[3:2])
        2'd1:    return 32'(mdl_len);
        2'd2:    return {30'd0, mdl_done, busy};
        default: return 32'd0;
      endcase
    end
    return mdl_mem[a[11:2]];
  endfunction

  task automatic mdl_write(input logic [31:0] a, input logic [31:0] d);
    logic busy;
    busy = (exp_q.size() != 0);
    if (a[12]) begin
      if (a[3:2] == 2'd0 && d[0] && !busy && mdl_len != 0) begin
        for (int i = 0; i < int'(mdl_len); i++) begin
          exp_t        e;
          logic [31:0] w;
          w   = mdl_mem[i / 4];
          e.d = 8'(w >> (8 * (i % 4)));
          e.l = (i == int'(mdl_len) - 1);
          exp_q.push_back(e);
        end
        mdl_done = 1'b0;
      end else if (a[3:2] == 2'd1 && !busy) begin
        mdl_len = (d > 32'd4096) ? 4096 : d;
      end
    end else if (!busy) begin
      mdl_mem[a[11:2]] = d;
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic apb_xfer(input logic [31:0] a, input logic wr, input logic [31:0] wd,
                          output logic [31:0] rd, output logic err);
    int lat;
    lat = -1;
    step();
    paddr = a; pwrite = wr; pwdata = wd; psel = 1'b1; penable = 1'b0;
    step();
    penable = 1'b1;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (pready) begin
        lat = i;
        break;
      end
    end
    rd  = prdata;
    err = pslverr;
    chk("apb_pready_latency", 32'(lat), 32'd1);
    step();
    psel = 1'b0; penable = 1'b0; pwrite = 1'b0;
  endtask

  task automatic apb_wr(input logic [31:0] a, input logic [31:0] d, output logic err);
    logic [31:0] rd;
    logic        exp_err;
    exp_err = !a[12] && (exp_q.size() != 0);
    mdl_write(a, d);
    apb_xfer(a, 1'b1, d, rd, err);
    chk("apb_wr_pslverr", 32'(err), 32'(exp_err));
  endtask

  task automatic apb_rd(input logic [31:0] a, input string name, output logic [31:0] rd);
    logic err;
    apb_xfer(a, 1'b0, 32'd0, rd, err);
    chk(name, rd, mdl_read(a));
    chk("apb_rd_pslverr", 32'(err), 32'd0);
  endtask

  task automatic wait_drain(input int limit);
    int n;
    n = 0;
    while ((exp_q.size() != 0 || tvalid) && n < limit) begin
      step();
      n++;
    end
    chk("drain_timeout", 32'(exp_q.size()), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] rd;
    logic        err;
    int          hs_base;
    int          vcnt;

    rst_n = 1'b0; psel = 1'b0; penable = 1'b0; pwrite = 1'b0;
    paddr = '0; pwdata = '0; tready = 1'b0;
    mdl_len = 0; mdl_done = 1'b0;
    for (int i = 0; i < 1024; i++) mdl_mem[i] = '0;

    repeat (3) step();
    chk("rst_prdata",  prdata,         32'd0);
    chk("rst_pready",  32'(pready),    32'd0);
    chk("rst_pslverr", 32'(pslverr),   32'd0);
    chk("rst_tvalid",  32'(tvalid),    32'd0);
    chk("rst_tlast",   32'(tlast),     32'd0);
    chk("rst_tdata",   32'(tdata),     32'd0);
    chk("rst_tkeep",   32'(tkeep),     32'd1);
    rst_n = 1'b1;
    step();
    apb_rd(32'h1008, "status_after_reset", rd);
    chk("status_after_reset_lit", rd, 32'h0);
    apb_rd(32'h1004, "len_after_reset", rd);

    // LEN=0 never starts; oversize LEN saturates
    apb_wr(32'h1004, 32'd0, err);
    apb_wr(32'h1000, 32'd1, err);
    vcnt = 0;
    for (int i = 0; i < 10; i++) begin
      step();
      if (tvalid) vcnt++;
    end
    chk("len0_tvalid_cycles", 32'(vcnt), 32'd0);
    apb_rd(32'h1008, "status_len0", rd);
    chk("status_len0_lit", rd, 32'h0);
    apb_wr(32'h1004, 32'd5000, err);
    apb_rd(32'h1004, "len_saturated", rd);
    chk("len_saturated_lit", rd, 32'd4096);
    apb_rd(32'h1000, "ctrl_reads_zero", rd);
    apb_rd(32'h100C, "unmapped_reads_zero", rd);

    // Top word of the buffer round-trips
    apb_wr(32'h0FFC, 32'hDEADBEEF, err);
    apb_rd(32'h0FFC, "buf_top_word", rd);
    chk("buf_top_word_lit", rd, 32'hDEADBEEF);

    // LEN=6, tready high: 11 22 33 44, bubble, 55 66
    apb_wr(32'h0000, 32'h44332211, err);
    apb_wr(32'h0004, 32'h88776655, err);
    apb_wr(32'h1004, 32'd6, err);
    acc_q.delete();
    hs_base = hs_count;
    tready  = 1'b1;
    apb_wr(32'h1000, 32'd1, err);
    wait_drain(200);
    chk("len6_handshakes", 32'(hs_count - hs_base), 32'd6);
    chk("len6_span_cycles", 32'(last_cyc - first_cyc + 1), 32'd7);
    chk("len6_tlast_count", 32'(last_count), 32'd1);
    chk("len6_acc_size", 32'(acc_q.size()), 32'd6);
    if (acc_q.size() == 6) begin
      chk("len6_byte0_lit", 32'(acc_q[0]), 32'h11);
      chk("len6_byte3_lit", 32'(acc_q[3]), 32'h44);
      chk("len6_byte4_lit", 32'(acc_q[4]), 32'h55);
      chk("len6_byte5_lit", 32'(acc_q[5]), 32'h66);
    end
    apb_rd(32'h1008, "status_done", rd);
    chk("status_done_lit", rd, 32'h2);

    // LEN=4 with tready toggling: stalled cycles must hold tdata/tlast
    apb_wr(32'h1004, 32'd4, err);
    acc_q.delete();
    hs_base = hs_count;
    tready  = 1'b0;
    apb_wr(32'h1000, 32'd1, err);
    for (int i = 0; i < 100 && (exp_q.size() != 0 || tvalid); i++) begin
      tready = ~tready;
      step();
    end
    chk("len4_drain", 32'(exp_q.size()), 32'd0);
    chk("len4_handshakes", 32'(hs_count - hs_base), 32'd4);
    chk("len4_tlast_count", 32'(last_count), 32'd2);
    if (acc_q.size() == 4) chk("len4_byte3_lit", 32'(acc_q[3]), 32'h44);

    // While busy: buffer write errors, START and LEN ignored, reads allowed
    tready = 1'b0;
    apb_wr(32'h1004, 32'd8, err);
    acc_q.delete();
    hs_base = hs_count;
    apb_wr(32'h1000, 32'd1, err);
    apb_wr(32'h0000, 32'h12345678, err);
    chk("busy_buf_wr_err_lit", 32'(err), 32'd1);
    apb_wr(32'h1004, 32'd100, err);
    apb_wr(32'h1000, 32'd1, err);
    apb_rd(32'h1008, "status_busy", rd);
    chk("status_busy_lit", rd, 32'h1);
    apb_rd(32'h1004, "len_busy", rd);
    chk("len_busy_lit", rd, 32'd8);
    apb_rd(32'h0000, "buf_busy_read", rd);
    chk("buf_busy_read_lit", rd, 32'h44332211);
    tready = 1'b1;
    wait_drain(200);
    chk("len8_handshakes", 32'(hs_count - hs_base), 32'd8);
    if (acc_q.size() == 8) chk("len8_byte7_lit", 32'(acc_q[7]), 32'h88);

    // Reset after 3 handshakes of an 8-byte transfer
    hs_base = hs_count;
    apb_wr(32'h1000, 32'd1, err);
    vcnt = 0;
    while (hs_count < hs_base + 3 && vcnt < 50) begin
      @(posedge clk);
      #2;
      vcnt++;
    end
    chk("mid_reset_reached", 32'(hs_count - hs_base), 32'd3);
    rst_n = 1'b0;
    #1;
    chk("mid_reset_tvalid", 32'(tvalid), 32'd0);
    chk("mid_reset_tlast",  32'(tlast),  32'd0);
    exp_q.delete();
    mdl_done = 1'b0;
    mdl_len  = 0;
    in_xfer  = 1'b0;
    repeat (2) step();
    rst_n = 1'b1;
    apb_rd(32'h1008, "status_after_mid_reset", rd);
    chk("status_after_mid_reset_lit", rd, 32'h0);
    apb_rd(32'h1004, "len_after_mid_reset", rd);
    apb_rd(32'h0004, "buf_kept_over_reset", rd);
    chk("buf_kept_over_reset_lit", rd, 32'h88776655);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
